s2p_frame_deser: RTL and testbench

Parametrised multi-word serial-to-parallel deserializer for the EEG ADC data path. It captures a framed serial stream of NUM_WORDS words of WORD_W bits each, such as a status word followed by channel samples. The stream is clocked by an external serial clock and sampled entirely in the system `clk` domain. Each completed word is presented with its index and a one-cycle valid strobe for the downstream packer/FIFO.

---
 rtl/s2p_frame_deser.sv | 186 ++++++++++++++++++
 tb/tb_s2p_frame_deser.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_frame_deser.sv
// -----------------------------------------------------------------------------
// s2p_frame_deser
//
// This block deserializes a framed serial stream from the EEG ADC. Each frame
// holds NUM_WORDS words of WORD_W bits: a status word followed by channel
// samples. serial_clk and serial_in are asynchronous to clk. Both pass through
// synchronizers of equal depth and are then sampled entirely in the clk domain.
// Each completed word is presented with its index and a one-cycle strobe.
//
// Optional feature macro: S2P_HDR_CHECK_EN
//   When it is defined, the top 4 bits of word 0 are compared to the ADC status
//   header 4'hC, and hdr_err pulses with word 0's word_valid on a mismatch.
//   This feature needs WORD_W >= 4.
//   When it is undefined, hdr_err is tied to 0.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   serial_clk    in   ADC serial clock (asynchronous to clk)
//   serial_in     in   ADC serial data, valid at the serial_clk rising edge
//   frame_start   in   one-clk pulse that marks the start of a frame
//   s2p_en        in   capture enable; when low, the counters and the shifter are frozen
//   parallel_out  out  last completed word
//   word_idx      out  index of parallel_out within the frame
//   word_valid    out  one-clk pulse: parallel_out/word_idx were updated
//   frame_done    out  one-clk pulse with the word_valid of the last word
//   frame_err     out  one-clk pulse: frame aborted by an early frame_start
//   busy          out  high while a frame is being shifted in
//   hdr_err       out  status-header mismatch on word 0 (see macro above)
// -----------------------------------------------------------------------------
module s2p_frame_deser #(
  parameter int WORD_W    = 24,
  parameter int NUM_WORDS = 9,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_clk,
  input  logic              serial_in,
  input  logic              frame_start,
  input  logic              s2p_en,
  output logic [WORD_W-1:0] parallel_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic              hdr_err
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_sck_sync;
  logic [1:0]         r_sdi_sync;
  logic [WORD_W-1:0]  r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [IDX_W-1:0]   r_word_cnt;
  logic [WORD_W-1:0]  r_parallel;
  logic [IDX_W-1:0]   r_word_idx;
  logic               r_word_valid;
  logic               r_frame_done;
  logic               r_frame_err;

  logic               w_sck_rise;
  logic               w_sdi;
  logic               w_shift_en;
  logic               w_word_done;
  logic               w_last_word;
  logic               w_abort;
  logic [WORD_W-1:0]  w_shift_nxt;

  // Stage [1] of both chains carries the same sample point. Stage [2] of the
  // clock chain exists only to detect the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // reads the values from before the clock edge.
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], serial_clk};
      r_sdi_sync <= {r_sdi_sync[0], serial_in};
    end
  end

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sdi       = r_sdi_sync[1];

  assign w_shift_en  = (r_state == S_SHIFT) && w_sck_rise && s2p_en;
  assign w_word_done = w_shift_en && (r_bit_cnt == LAST_BIT);
  assign w_last_word = w_word_done && (r_word_cnt == LAST_WORD);
  // A restart that coincides with the final bit of the frame is a clean
  // back-to-back frame, not an abort.
  assign w_abort     = frame_start && (r_state == S_SHIFT) && !w_last_word;

  assign w_shift_nxt = MSB_FIRST ? {r_shift[WORD_W-2:0], w_sdi}
                                 : {w_sdi, r_shift[WORD_W-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: assign a default first, so that no path through this block leaves
    // w_state_nxt unassigned (which would infer a latch).
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (frame_start)      w_state_nxt = S_SHIFT;
               else if (w_last_word) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is cleared on reset as well, so that a reset in
      // mid-frame can never leak partial bits into a later word.
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_parallel   <= '0;
      r_word_idx   <= '0;
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_word_valid <= w_word_done;
      r_frame_done <= w_last_word;
      r_frame_err  <= w_abort;

      // A word that completes in the same cycle as frame_start is still delivered.
      if (w_word_done) begin
        r_parallel <= w_shift_nxt;
        r_word_idx <= r_word_cnt;
      end

      if (frame_start) begin
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift <= w_shift_nxt;
        if (w_word_done) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
        end else begin
          r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef S2P_HDR_CHECK_EN
  logic r_hdr_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hdr_err <= 1'b0;
    else        r_hdr_err <= w_word_done && (r_word_cnt == '0) &&
                             (w_shift_nxt[WORD_W-1 -: 4] != 4'hC);
  end

  assign hdr_err = r_hdr_err;
`else
  assign hdr_err = 1'b0;
`endif

  assign parallel_out = r_parallel;
  assign word_idx     = r_word_idx;
  assign word_valid   = r_word_valid;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;
  assign busy         = (r_state == S_SHIFT);

endmodule

// File: tb/tb_s2p_frame_deser.sv
// -----------------------------------------------------------------------------
// Self-checking bench for s2p_frame_deser.
// - dut    : default configuration (24-bit words, 9 words, MSB first)
// - dut_l  : the same stream, captured LSB first
// Stimulus is directed; every expected word is written out by hand.
// -----------------------------------------------------------------------------
module tb_s2p_frame_deser;

`ifdef S2P_HDR_CHECK_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_clk;
  logic        serial_in;
  logic        frame_start;
  logic        s2p_en;

  logic [23:0] parallel_out;
  logic [3:0]  word_idx;
  logic        word_valid, frame_done, frame_err, busy, hdr_err;

  logic [23:0] l_parallel_out;
  logic [3:0]  l_word_idx;
  logic        l_word_valid, l_frame_done, l_frame_err, l_busy, l_hdr_err;

  s2p_frame_deser dut (
    .clk(clk), .reset(reset), .serial_clk(serial_clk), .serial_in(serial_in),
    .frame_start(frame_start), .s2p_en(s2p_en),
    .parallel_out(parallel_out), .word_idx(word_idx), .word_valid(word_valid),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy), .hdr_err(hdr_err)
  );

  s2p_frame_deser #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_clk(serial_clk), .serial_in(serial_in),
    .frame_start(frame_start), .s2p_en(s2p_en),
    .parallel_out(l_parallel_out), .word_idx(l_word_idx), .word_valid(l_word_valid),
    .frame_done(l_frame_done), .frame_err(l_frame_err), .busy(l_busy), .hdr_err(l_hdr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge.
  logic [23:0] q_data[$];
  int          q_idx[$];
  bit          q_done[$];
  bit          q_hdr[$];
  logic [23:0] ql_data[$];
  int          n_ferr  = 0;
  int          n_fdone = 0;

  always @(negedge clk) begin
    if (word_valid) begin
      q_data.push_back(parallel_out);
      q_idx.push_back(int'(word_idx));
      q_done.push_back(frame_done);
      q_hdr.push_back(hdr_err);
    end
    if (l_word_valid) ql_data.push_back(l_parallel_out);
    if (frame_err)  n_ferr++;
    if (frame_done) n_fdone++;
  end

  task automatic clear_q();
    q_data.delete(); q_idx.delete(); q_done.delete(); q_hdr.delete(); ql_data.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each serial_clk phase lasts 3 clk periods; data changes while serial_clk is low.
  task automatic send_bit(input logic b);
    serial_in  = b;
    serial_clk = 1'b0;
    wait_clk(3);
    serial_clk = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 23, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  logic [23:0] exp_w [9];

  task automatic send_frame();
    for (int i = 0; i < 9; i++) send_word(exp_w[i]);
    serial_clk = 1'b0;
    wait_clk(6);
  endtask

  task automatic check_frame(input string tag, input bit hdr0);
    check({tag, ".count"}, q_data.size(), 9);
    for (int i = 0; i < 9 && i < q_data.size(); i++) begin
      check($sformatf("%s.data%0d", tag, i), q_data[i], exp_w[i]);
      check($sformatf("%s.idx%0d", tag, i), q_idx[i], i);
      check($sformatf("%s.done%0d", tag, i), q_done[i], (i == 8));
      check($sformatf("%s.hdr%0d", tag, i), q_hdr[i], (i == 0) ? hdr0 : 1'b0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".pout"},  parallel_out, 0);
    check({tag, ".idx"},   word_idx, 0);
    check({tag, ".valid"}, word_valid, 0);
    check({tag, ".done"},  frame_done, 0);
    check({tag, ".err"},   frame_err, 0);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".hdr"},   hdr_err, 0);
  endtask

  initial begin
    reset = 1'b0; serial_clk = 1'b0; serial_in = 1'b0; frame_start = 1'b0; s2p_en = 1'b1;
    wait_clk(3);
    check_idle_outputs("rst");
    reset = 1'b1;
    wait_clk(3);

    // Frame 1: status word followed by samples 1..8.
    exp_w = '{24'hC00000, 24'h000001, 24'h000002, 24'h000003, 24'h000004,
              24'h000005, 24'h000006, 24'h000007, 24'h000008};
    clear_q();
    pulse_start();
    check("f1.busy_start", busy, 1);
    send_frame();
    check_frame("f1", 1'b0);
    check("f1.busy_end", busy, 0);
    check("f1.fdone_cnt", n_fdone, 1);
    check("f1.ferr_cnt", n_ferr, 0);

    // LSB-first capture of word 0, then an abort after 5 words + 10 bits.
    clear_q();
    pulse_start();
    send_word(24'hA5F00F);
    send_word(24'h000001);
    send_word(24'h000002);
    send_word(24'h000003);
    send_word(24'h000004);
    send_bits(24'hABCDEF, 23, 14);
    wait_clk(4);
    check("ab.count_pre", q_data.size(), 5);
    check("lsb.word0", ql_data.size() > 0 ? ql_data[0] : 24'hxxxxxx, 24'hF00FA5);
    check("ab.hdr0", q_data.size() > 0 ? q_hdr[0] : 1'bx, HDR_ON);
    pulse_start();
    wait_clk(3);
    check("ab.ferr_cnt", n_ferr, 1);
    check("ab.count_post", q_data.size(), 5);
    check("ab.pout_hold", parallel_out, 24'h000004);
    check("ab.idx_hold", word_idx, 4);
    check("ab.busy", busy, 1);

    // The restarted frame runs to completion.
    exp_w = '{24'hC12345, 24'h000011, 24'h000012, 24'h000013, 24'h000014,
              24'h000015, 24'h000016, 24'h000017, 24'h000018};
    clear_q();
    send_frame();
    check_frame("f2", 1'b0);
    check("f2.fdone_cnt", n_fdone, 2);

    // s2p_en low for 7 serial_clk rising edges in mid-word.
    clear_q();
    pulse_start();
    send_bits(24'hC23456, 23, 12);
    wait_clk(4);
    s2p_en = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    wait_clk(4);
    s2p_en = 1'b1;
    send_bits(24'hC23456, 11, 0);
    send_word(24'h000777);
    serial_clk = 1'b0;
    wait_clk(6);
    check("en.count", q_data.size(), 2);
    check("en.word0", q_data.size() > 0 ? q_data[0] : 24'hxxxxxx, 24'hC23456);
    check("en.word1", q_data.size() > 1 ? q_data[1] : 24'hxxxxxx, 24'h000777);
    check("en.idx1",  q_data.size() > 1 ? q_idx[1] : -1, 1);

    // Reset during word 3, then a clean frame with a bad status header.
    send_word(24'h000888);
    send_bits(24'hFFFFFF, 23, 16);
    @(negedge clk);
    reset = 1'b0;
    serial_clk = 1'b0;
    wait_clk(2);
    check_idle_outputs("mrst");
    reset = 1'b1;
    wait_clk(3);
    exp_w = '{24'h800000, 24'h000021, 24'h000022, 24'h000023, 24'h000024,
              24'h000025, 24'h000026, 24'h000027, 24'h000028};
    clear_q();
    pulse_start();
    send_frame();
    check_frame("f3", HDR_ON);
    check("f3.fdone_cnt", n_fdone, 3);
    check("f3.ferr_cnt", n_ferr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
